// File: rtl/conv1_fea_feeder.sv
// Input-feature feeder for the conv1 dense top: FIFO-buffers the source stream and emits one burst
// per need_data request. Define CONV1_FEEDER_PAD_EN to zero-pad the short final burst of a frame.
module conv1_fea_feeder #(
  parameter int unsigned DW      = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned BURST   = 4,
  parameter int unsigned FEA_NUM = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          need_data,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  output logic          src_ready,
  output logic          data_v,
  output logic [DW-1:0] in_fea,
  output logic          busy,
  output logic          done,
  output logic          req_drop
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = $clog2(FEA_NUM + 1);
  localparam int unsigned BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {StIdle, StWait, StHold, StBurst} state_e;

  state_e        state_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] remain_q, need;
  logic [BW-1:0] beat_q, beat_total;
  logic          pend_q;
  logic          push, pop, launch, emit, pad_beat;

  always_comb begin
    need   = (32'(remain_q) < BURST) ? remain_q : RW'(BURST);
    launch = (state_q == StHold) && (32'(count_q) >= 32'(need));
    // beat_q counts the beats still to come after the one currently on the outputs
    emit   = launch || ((state_q == StBurst) && (beat_q != '0));
`ifdef CONV1_FEEDER_PAD_EN
    beat_total = BW'(BURST);
    pad_beat   = (remain_q == '0);
`else
    beat_total = BW'(need);
    pad_beat   = 1'b0;
`endif
    push = src_valid && src_ready;
    pop  = emit && !pad_beat;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= src_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      src_ready <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_d;
      src_ready <= (32'(count_d) < DEPTH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      remain_q <= '0;
      beat_q   <= '0;
      pend_q   <= 1'b0;
      data_v   <= 1'b0;
      in_fea   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      req_drop <= 1'b0;
    end else begin
      done <= 1'b0;
      if (need_data && (state_q != StIdle)) begin
        if (pend_q) req_drop <= 1'b1;
        else        pend_q   <= 1'b1;
      end

      data_v <= emit;
      if (emit) begin
        in_fea <= pad_beat ? '0 : mem_q[rd_ptr_q];
        if (!pad_beat) remain_q <= remain_q - RW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            remain_q <= RW'(FEA_NUM);
            req_drop <= 1'b0;
            busy     <= 1'b1;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (pend_q || need_data) state_q <= StHold;
        end
        StHold: begin
          if (launch) begin
            pend_q  <= 1'b0;
            beat_q  <= beat_total - BW'(1);
            state_q <= StBurst;
          end
        end
        StBurst: begin
          if (beat_q != '0) begin
            beat_q <= beat_q - BW'(1);
          end else if (remain_q == '0) begin
            // a request landing on the frame's final beat has nothing left to serve
            pend_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StIdle;
          end else if (pend_q || need_data) begin
            state_q <= StHold;
          end else begin
            state_q <= StWait;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1_fea_feeder.sv
// Bench for conv1_fea_feeder: directed frame scenarios with literal expectations, then random
// traffic, with every cycle compared against a queue-based frame/request model.
module tb_conv1_fea_feeder;
  localparam int DW      = 8;
  localparam int DEPTH   = 16;
  localparam int BURST   = 4;
  localparam int FEA_NUM = 10;
`ifdef CONV1_FEEDER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, need_data, src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready, data_v, busy, done, req_drop;
  logic [DW-1:0] in_fea;

  conv1_fea_feeder #(
    .DW     (DW),
    .DEPTH  (DEPTH),
    .BURST  (BURST),
    .FEA_NUM(FEA_NUM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .need_data(need_data),
    .src_valid(src_valid),
    .src_data (src_data),
    .src_ready(src_ready),
    .data_v   (data_v),
    .in_fea   (in_fea),
    .busy     (busy),
    .done     (done),
    .req_drop (req_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int seq      = 1;

  // Model: FIFO as a queue, the current burst as a list of pad flags, frame as a word budget.
  logic [DW-1:0] m_q[$];
  bit            m_beats[$];
  int            m_left;
  bit            m_in_frame, m_pend, m_pushed;
  logic          e_src_ready, e_data_v, e_busy, e_done, e_req_drop;
  logic [DW-1:0] e_in_fea;

  task automatic model_reset();
    m_q.delete();
    m_beats.delete();
    m_left = 0; m_in_frame = 0; m_pend = 0; m_pushed = 0;
    e_src_ready = 1; e_data_v = 0; e_in_fea = '0; e_busy = 0; e_done = 0; e_req_drop = 0;
  endtask

  task automatic model_step();
    bit was_in_frame, cur_beat, holding, launch, is_pad;
    int n_need, total;
    was_in_frame = m_in_frame;
    cur_beat     = e_data_v;
    n_need       = (m_left < BURST) ? m_left : BURST;
    // a request is waiting for data whenever one is pending and no burst is on the wire
    holding      = m_in_frame && m_pend && !cur_beat;
    launch       = holding && (m_q.size() >= n_need);
    m_pushed     = src_valid && e_src_ready;
    if (was_in_frame && need_data) begin
      if (m_pend) e_req_drop = 1;
      else        m_pend     = 1;
    end
    e_done = 0;
    if (launch) begin
      m_pend = 0;
      total  = PAD ? BURST : n_need;
      for (int i = 0; i < total; i++) m_beats.push_back(i >= m_left);
    end
    if (m_beats.size() > 0) begin
      is_pad   = m_beats.pop_front();
      e_data_v = 1;
      if (is_pad) e_in_fea = '0;
      else begin
        e_in_fea = m_q.pop_front();
        m_left--;
      end
    end else begin
      e_data_v = 0;
      if (cur_beat && m_left == 0) begin
        m_in_frame = 0; m_pend = 0; e_done = 1; e_busy = 0;
      end
    end
    if (!was_in_frame && start) begin
      m_in_frame = 1; m_left = FEA_NUM; e_req_drop = 0; e_busy = 1;
    end
    if (m_pushed) m_q.push_back(src_data);
    e_src_ready = (m_q.size() < DEPTH);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        n_checks++;
        if ({src_ready, data_v, in_fea, busy, done, req_drop} ===
            {e_src_ready, e_data_v, e_in_fea, e_busy, e_done, e_req_drop}) begin
          n_pass++;
        end else begin
          $display("FAIL outputs (cycle %0d): got rdy=%0b v=%0b fea=%0d busy=%0b done=%0b drop=%0b, expected rdy=%0b v=%0b fea=%0d busy=%0b done=%0b drop=%0b",
                   cyc, src_ready, data_v, in_fea, busy, done, req_drop,
                   e_src_ready, e_data_v, e_in_fea, e_busy, e_done, e_req_drop);
        end
      end
    end
  end

  initial begin
    int first_v, last_v, done_cyc, acc, s0;
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_words[$];
    model_reset();
    rst = 1; start = 0; need_data = 0; src_valid = 0; src_data = '0;
    first_v = -1; last_v = -1; done_cyc = -1;

    // Reset, start at 7, requests at 11/33/55, source counting 1,2,3...
    for (int c = 0; c < 75; c++) begin
      rst       = (c < 5);
      src_valid = (c >= 5);
      start     = (c == 7);
      need_data = (c == 11) || (c == 33) || (c == 55);
      src_data  = DW'(seq);
      if (c == 5) begin
        check("reset src_ready", int'(src_ready), 1);
        check("reset data_v", int'(data_v), 0);
        check("reset in_fea", int'(in_fea), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset req_drop", int'(req_drop), 0);
      end
      if (c == 8)  check("busy after start", int'(busy), 1);
      if (c == 12) check("hold cycle data_v", int'(data_v), 0);
      if (data_v === 1'b1) begin
        got.push_back(in_fea);
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (done === 1'b1) done_cyc = c;
      tick();
      if (m_pushed) seq++;
    end
    for (int i = 1; i <= FEA_NUM; i++) exp_words.push_back(DW'(i));
    if (PAD) begin
      exp_words.push_back('0);
      exp_words.push_back('0);
    end
    check("frame word count", got.size(), exp_words.size());
    for (int i = 0; i < got.size() && i < exp_words.size(); i++)
      check("frame word", int'(got[i]), int'(exp_words[i]));
    check("first beat cycle", first_v, 13);
    check("last beat cycle", last_v, PAD ? 60 : 58);
    check("done cycle", done_cyc, PAD ? 61 : 59);
    check("busy after frame", int'(busy), 0);

    // Overlapped requests on beats 1 and 3 of a burst
    for (int r = 0; r <= 40; r++) begin
      start     = (r == 0) || (r == 35);
      need_data = (r == 2) || (r == 4) || (r == 6) || (r == 20) || (r == 30);
      src_valid = 1;
      src_data  = DW'(seq);
      if (r == 3)  check("overlap hold data_v", int'(data_v), 0);
      if (r == 5)  check("first overlap no drop", int'(req_drop), 0);
      if (r == 7)  check("second overlap drops", int'(req_drop), 1);
      if (r == 9)  check("pending burst served", int'(data_v), 1);
      if (r == 28) check("drop sticky after frame", int'(req_drop), 1);
      if (r == 36) check("drop cleared by start", int'(req_drop), 0);
      tick();
      if (m_pushed) seq++;
    end

    // Asynchronous reset in the middle of a burst
    start = 0; need_data = 1; src_data = DW'(seq);
    tick();
    if (m_pushed) seq++;
    need_data = 0; src_data = DW'(seq);
    tick();
    if (m_pushed) seq++;
    check("beat before reset", int'(data_v), 1);
    rst = 1;
    #1;
    check("async reset data_v", int'(data_v), 0);
    check("async reset busy", int'(busy), 0);
    check("async reset src_ready", int'(src_ready), 1);
    src_valid = 0;
    tick();
    tick();
    rst = 0;

    // Starved source: data only 20 cycles after the request
    acc = 0; first_v = -1; s0 = 0;
    for (int r = 0; r < 45; r++) begin
      start     = (r == 0);
      need_data = (r == 2);
      src_valid = (r >= 22);
      src_data  = DW'(seq);
      if (r == 22) s0 = seq;
      if (r < 22 && data_v === 1'b1) acc++;
      if (data_v === 1'b1 && first_v < 0) begin
        first_v = r;
        check("starved first word", int'(in_fea), s0 & 255);
      end
      tick();
      if (m_pushed) seq++;
    end
    check("starved no early beats", acc, 0);
    check("starved burst start", first_v, 27);

    // Back-pressure: fill an empty FIFO with no requests
    rst = 1; src_valid = 0; start = 0; need_data = 0;
    tick();
    rst = 0;
    acc = 0; s0 = seq;
    for (int r = 0; r < 20; r++) begin
      src_valid = 1;
      src_data  = DW'(seq);
      if (src_ready === 1'b1) acc++;
      tick();
      if (m_pushed) seq++;
    end
    check("accepted before full", acc, DEPTH);
    check("src_ready when full", int'(src_ready), 0);
    for (int r = 0; r < 9; r++) begin
      start     = (r == 0);
      need_data = (r == 2);
      src_data  = DW'(seq);
      if (r == 4) begin
        check("drain first word", int'(in_fea), s0 & 255);
        check("src_ready after pop", int'(src_ready), 1);
      end
      tick();
      if (m_pushed) seq++;
    end

    // Random traffic, including occasional resets
    for (int i = 0; i < 5000; i++) begin
      rst       = ($urandom_range(0, 599) == 0);
      start     = ($urandom_range(0, 15) == 0);
      need_data = ($urandom_range(0, 4) == 0);
      src_valid = ($urandom_range(0, 3) != 0);
      src_data  = DW'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
